// File: rtl/compare_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit comparator among NREQ req/ack clients.
// Three cycles per transaction; define COMPARE_SIGNED_EN for two's-complement ordering flags.
module compare_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       ack,
  output logic                  valid,
  output logic [IDW-1:0]        result_id,
  output logic                  eq,
  output logic                  neq,
  output logic                  lt,
  output logic                  lte,
  output logic                  gt,
  output logic                  gte,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, COMPARE, RESPOND} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [NREQ-1:0]  r_ack;
  logic             r_valid;
  logic [IDW-1:0]   r_rid;
  logic [5:0]       r_flags;

  logic             w_gnt_vld;
  logic [IDW-1:0]   w_gnt_idx;
  int               w_best;
  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_sel;
  logic             w_eq;
  logic             w_lt;

  // Winner is the requester with the smallest circular distance from the pointer.
  always_comb begin
    w_gnt_vld = |req;
    w_gnt_idx = '0;
    w_best    = NREQ;
    for (int j = 0; j < NREQ; j++) begin
      if (req[j] && (((j + NREQ - int'(r_ptr)) % NREQ) < w_best)) begin
        w_best    = (j + NREQ - int'(r_ptr)) % NREQ;
        w_gnt_idx = IDW'(j);
      end
    end
  end

  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (IDW'(j) == w_gnt_idx) begin
        w_a_sel = a_in[j*WIDTH +: WIDTH];
        w_b_sel = b_in[j*WIDTH +: WIDTH];
      end
    end
  end

  assign w_eq = (r_a == r_b);
`ifdef COMPARE_SIGNED_EN
  assign w_lt = ($signed(r_a) < $signed(r_b));
`else
  assign w_lt = (r_a < r_b);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_ack   <= '0;
      r_valid <= 1'b0;
      r_rid   <= '0;
      r_flags <= '0;
    end else begin
      r_ack   <= '0;
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_a     <= w_a_sel;
            r_b     <= w_b_sel;
            r_id    <= w_gnt_idx;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          // Flag order: eq, neq, lt, lte, gt, gte
          r_flags <= {w_eq, !w_eq, w_lt, (w_lt | w_eq), !(w_lt | w_eq), !w_lt};
          r_rid   <= r_id;
          r_state <= RESPOND;
        end
        RESPOND: begin
          r_ack   <= {{(NREQ-1){1'b0}}, 1'b1} << r_id;
          r_valid <= 1'b1;
          r_ptr   <= (r_id == IDW'(NREQ-1)) ? '0 : r_id + IDW'(1);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign valid     = r_valid;
  assign result_id = r_rid;
  assign eq        = r_flags[5];
  assign neq       = r_flags[4];
  assign lt        = r_flags[3];
  assign lte       = r_flags[2];
  assign gt        = r_flags[1];
  assign gte       = r_flags[0];
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_compare_arbiter.sv
// Bench for compare_arbiter: directed scenarios plus random requesters checked against a timeline model.
module tb_compare_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       ack;
  logic                  valid;
  logic [IDW-1:0]        result_id;
  logic                  eq, neq, lt, lte, gt, gte, busy;

  compare_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .valid(valid), .result_id(result_id),
    .eq(eq), .neq(neq), .lt(lt), .lte(lte), .gt(gt), .gte(gte), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model timeline: edges are counted; a grant at edge N means ack after edge N+2.
  int edge_cnt = 0;
  int ptr = 0;
  int next_free = 0;
  int grant_edge = -100;
  int ack_edge = -100;
  int exp_id = 0;
  int exp_rid = 0;
  logic [WIDTH-1:0] exp_a, exp_b;
  logic [5:0] exp_flags = '0;
  bit agents_on = 1'b0;
  bit active [NREQ];
  bit granted [NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  function automatic logic [5:0] rel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int x, y;
    x = int'(a);
    y = int'(b);
`ifdef COMPARE_SIGNED_EN
    if (x >= 2**(WIDTH-1)) x = x - 2**WIDTH;
    if (y >= 2**(WIDTH-1)) y = y - 2**WIDTH;
`endif
    return {x == y, x != y, x < y, x <= y, x > y, x >= y};
  endfunction

  function automatic logic [5:0] dut_flags();
    return {eq, neq, lt, lte, gt, gte};
  endfunction

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom % 4)
      0:       return '0;
      1:       return '1;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic new_request(input int i);
    logic [WIDTH-1:0] a;
    a = rnd_op();
    active[i] = 1'b1;
    req[i] = 1'b1;
    set_ops(i, a, ($urandom % 3 == 0) ? a : rnd_op());
  endtask

  task automatic agents_drive();
    for (int i = 0; i < NREQ; i++) begin
      if (!active[i]) begin
        if ($urandom % 4 == 0) new_request(i);
      end else if (!granted[i]) begin
        if (req[i] && ($urandom % 40 == 0)) begin
          req[i] = 1'b0;
          active[i] = 1'b0;
        end
      end else begin
        if ($urandom % 8 == 0) set_ops(i, WIDTH'($urandom), WIDTH'($urandom));
        if ($urandom % 10 == 0) req[i] = 1'b0;
      end
    end
  endtask

  task automatic model_grant();
    int id;
    id = -1;
    if ((edge_cnt + 1 >= next_free) && (req != '0)) begin
      for (int k = 0; k < NREQ; k++)
        if (id < 0 && req[(ptr + k) % NREQ]) id = (ptr + k) % NREQ;
      grant_edge = edge_cnt + 1;
      ack_edge   = edge_cnt + 3;
      next_free  = edge_cnt + 4;
      exp_id     = id;
      ptr        = (id + 1) % NREQ;
      exp_a      = a_in[id*WIDTH +: WIDTH];
      exp_b      = b_in[id*WIDTH +: WIDTH];
      granted[id] = 1'b1;
    end
  endtask

  task automatic step();
    if (agents_on) agents_drive();
    model_grant();
    @(posedge clk);
    edge_cnt++;
    if (edge_cnt == grant_edge + 1) begin
      exp_flags = rel(exp_a, exp_b);
      exp_rid   = exp_id;
    end
    @(negedge clk);
    chk("ack", ack, (edge_cnt == ack_edge) ? (1 << exp_id) : 0);
    chk("valid", valid, edge_cnt == ack_edge);
    chk("busy", busy, (edge_cnt == grant_edge) || (edge_cnt == grant_edge + 1));
    chk("flags", dut_flags(), exp_flags);
    chk("result_id", result_id, exp_rid);
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) begin
        granted[i] = 1'b0;
        if (agents_on && ($urandom % 3 == 0)) new_request(i);
        else begin
          active[i] = 1'b0;
          req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_flags"}, dut_flags(), 0);
    chk({tag, "_rid"}, result_id, 0);
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    #1 check_zero("rst");
    grant_edge = -100;
    ack_edge = -100;
    next_free = 0;
    ptr = 0;
    exp_flags = '0;
    exp_rid = 0;
    req = '0;
    for (int i = 0; i < NREQ; i++) begin
      active[i] = 1'b0;
      granted[i] = 1'b0;
    end
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_until_ack(output int id, output int lat);
    id = -1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (valid === 1'b1) begin
        for (int k = 0; k < NREQ; k++) if (ack[k]) id = k;
        lat = n;
        break;
      end
    end
    if (lat == 0) chk("ack_timeout", 0, 1);
  endtask

  logic [5:0] cont_exp [NREQ] = '{6'b011100, 6'b011100, 6'b100101, 6'b010011};
  int id, lat;

  initial begin
    rst = 1'b1;
    req = '0;
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      active[i] = 1'b0;
      granted[i] = 1'b0;
    end
    #1 check_zero("init");
    @(negedge clk);
    rst = 1'b0;

    // Single request with equal operands
    req = 4'b0001;
    set_ops(0, 8'd1, 8'd1);
    run_until_ack(id, lat);
    chk("single_id", id, 0);
    chk("single_lat", lat, 3);
    chk("single_flags", dut_flags(), 6'b100101);
    chk("single_rid", result_id, 0);
    step();
    step();
    chk("hold_flags", dut_flags(), 6'b100101);
    chk("hold_valid", valid, 0);

    // All four contend; served in index order, one every 3 cycles
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_ops(i, WIDTH'(i), 8'd2);
    for (int k = 0; k < NREQ; k++) begin
      run_until_ack(id, lat);
      chk("cont_id", id, k);
      chk("cont_lat", lat, 3);
      chk("cont_flags", dut_flags(), cont_exp[k]);
    end

    // Pointer at 3 after serving 2 wraps to requester 0 first
    apply_reset();
    req = 4'b0100;
    set_ops(2, 8'd7, 8'd3);
    run_until_ack(id, lat);
    chk("rr_first", id, 2);
    req = 4'b0101;
    set_ops(0, 8'd3, 8'd7);
    run_until_ack(id, lat);
    chk("rr_wrap", id, 0);
    run_until_ack(id, lat);
    chk("rr_next", id, 2);

    // Operands change after the grant edge
    req = 4'b0010;
    set_ops(1, 8'd2, 8'd1);
    step();
    set_ops(1, 8'd0, 8'd1);
    run_until_ack(id, lat);
    chk("stab_id", id, 1);
    chk("stab_flags", dut_flags(), 6'b010011);

    // Reset while in COMPARE aborts the transaction
    req = 4'b0010;
    set_ops(1, 8'd5, 8'd5);
    step();
    apply_reset();
    repeat (4) step();
    req = 4'b0010;
    set_ops(1, 8'd9, 8'd4);
    run_until_ack(id, lat);
    chk("post_rst_id", id, 1);
    chk("post_rst_rid", result_id, 1);

    req = 4'b0001;
    set_ops(0, 8'hFF, 8'h01);
    run_until_ack(id, lat);
`ifdef COMPARE_SIGNED_EN
    chk("sign_flags", dut_flags(), 6'b011100);
`else
    chk("sign_flags", dut_flags(), 6'b010011);
`endif

    // Random requesters
    apply_reset();
    agents_on = 1'b1;
    repeat (2000) step();
    agents_on = 1'b0;
    req = '0;
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
